// File: rtl/bitcount_pkg.sv
// Shared types and helpers for the chunked bit-counting engine.
package bitcount_pkg;

  typedef enum logic [1:0] {
    ONES  = 2'b00,
    ZEROS = 2'b01,
    CLZ   = 2'b10,
    CTZ   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bitcount_slice.sv
// Combinational per-slice statistics: ones count, leading/trailing zero counts, any-one flag.
module bitcount_slice
  import bitcount_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]          slice,
  output logic [count_w(CHUNK)-1:0] ones,
  output logic [count_w(CHUNK)-1:0] lz,
  output logic [count_w(CHUNK)-1:0] tz,
  output logic                      any_one
);

  localparam int CW = count_w(CHUNK);

  logic lz_stop;
  logic tz_stop;

  always_comb begin
    ones    = '0;
    lz      = '0;
    tz      = '0;
    lz_stop = 1'b0;
    tz_stop = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      ones = ones + CW'(slice[i]);
      if (!tz_stop) begin
        if (slice[i]) tz_stop = 1'b1;
        else          tz      = tz + CW'(1);
      end
      if (!lz_stop) begin
        if (slice[CHUNK-1-i]) lz_stop = 1'b1;
        else                  lz      = lz + CW'(1);
      end
    end
    any_one = |slice;
  end

endmodule

// File: rtl/bitcount_chunked.sv
// Multi-cycle ONES/ZEROS/CLZ/CTZ counter processing CHUNK bits per cycle.
// Optional BITCOUNT_EARLY_EXIT_EN ends BUSY as soon as the result can no longer change.
module bitcount_chunked
  import bitcount_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          in,
  output logic                      busy,
  output logic                      finish,
  output logic [count_w(WIDTH)-1:0] bitcount
);

  localparam int N       = WIDTH / CHUNK;
  localparam int COUNT_W = count_w(WIDTH);
  localparam int SLICE_W = count_w(CHUNK);
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("bitcount_chunked: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               found_q, found_d;

  logic [CHUNK-1:0]   slice_in;
  logic [WIDTH-1:0]   shifted;
  logic [SLICE_W-1:0] slice_ones, slice_lz, slice_tz, add;
  logic               slice_any;
  logic               last_slice;
  logic               early_exit;

  bitcount_slice #(.CHUNK(CHUNK)) u_slice (
    .slice   (slice_in),
    .ones    (slice_ones),
    .lz      (slice_lz),
    .tz      (slice_tz),
    .any_one (slice_any)
  );

  // CTZ walks LSB-first, everything else MSB-first; vacated bits fill with zeros.
  always_comb begin
    if (mode_q == CTZ) begin
      slice_in = shreg_q[CHUNK-1:0];
      shifted  = shreg_q >> CHUNK;
    end else begin
      slice_in = shreg_q[WIDTH-1 -: CHUNK];
      shifted  = shreg_q << CHUNK;
    end
  end

  // ZEROS counts ones of the inverted operand captured into the shift register.
  always_comb begin
    add = '0;
    case (mode_q)
      ONES, ZEROS: add = slice_ones;
      CLZ:         add = found_q ? '0 : slice_lz;
      CTZ:         add = found_q ? '0 : slice_tz;
      default:     add = '0;
    endcase
    last_slice = (idx_q == IDX_W'(N - 1));
`ifdef BITCOUNT_EARLY_EXIT_EN
    if (mode_q == ONES || mode_q == ZEROS) early_exit = (shifted == '0);
    else                                   early_exit = found_q | slice_any;
`else
    early_exit = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    count_d = count_q;
    found_d = found_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          mode_d  = mode_t'(mode);
          shreg_d = (mode_t'(mode) == ZEROS) ? ~in : in;
          idx_d   = '0;
          count_d = '0;
          found_d = 1'b0;
        end
      end
      BUSY: begin
        shreg_d = shifted;
        idx_d   = idx_q + IDX_W'(1);
        count_d = count_q + COUNT_W'(add);
        found_d = found_q | slice_any;
        if (last_slice || early_exit) state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= ONES;
      shreg_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      found_q <= found_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign finish   = (state_q == DONE);
  assign bitcount = count_q;

endmodule

// File: tb/tb_bitcount_chunked.sv
// Scoreboard bench for bitcount_chunked (WIDTH=32, CHUNK=8); monitor checks result and latency.
module tb_bitcount_chunked;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] in_v = '0;
  logic        busy;
  logic        finish;
  logic [5:0]  bitcount;

  always #5 clk = ~clk;

  bitcount_chunked #(.WIDTH(32), .CHUNK(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .in       (in_v),
    .busy     (busy),
    .finish   (finish),
    .bitcount (bitcount)
  );

`ifdef BITCOUNT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic [5:0] cnt;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic int lat(input int normal_l, input int early_l);
    return EE ? early_l : normal_l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: on each rising finish, pop the oldest expectation and compare.
  initial begin
    int busy_cnt;
    bit fin_prev;
    exp_t e;
    busy_cnt = 0;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (finish && !fin_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected finish", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, " count"}, 32'(bitcount), 32'(e.cnt));
          check({e.name, " latency"}, busy_cnt, e.lat);
        end
        busy_cnt = 0;
      end
      if (!busy && !finish) busy_cnt = 0;
      fin_prev = finish;
    end
  end

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_op(input logic [1:0] m, input logic [31:0] v, input logic [5:0] e,
                        input int l, input int hold, input bit drop_early, input string name);
    int n;
    start = 1'b1;
    mode  = m;
    in_v  = v;
    sb_q.push_back('{cnt: e, lat: l, name: name});
    @(posedge clk);
    #1;
    check({name, " captured"}, 32'(busy), 32'd1);
    mode = ~m;
    in_v = ~v ^ 32'h5A5A_0F0F;
    if (drop_early) start = 1'b0;
    n = 0;
    while (!finish && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!finish) begin
      check({name, " finish timeout"}, 32'd0, 32'd1);
      start = 1'b0;
      @(negedge clk);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " hold finish"}, 32'(finish), 32'd1);
      check({name, " hold count"}, 32'(bitcount), 32'(e));
    end
    start = 1'b0;
    @(negedge clk);
    check({name, " finish drop"}, 32'(finish), 32'd0);
    check({name, " idle hold count"}, 32'(bitcount), 32'(e));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset finish", 32'(finish), 32'd0);
    check("reset bitcount", 32'(bitcount), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'hF852_4A22, 6'd13, lat(4, 4), 0, 1'b0, "ONES F8524A22");
    run_op(2'b10, 32'h0000_0800, 6'd20, lat(4, 3), 0, 1'b0, "CLZ 00000800");
    run_op(2'b11, 32'h0000_0800, 6'd11, lat(4, 2), 0, 1'b0, "CTZ 00000800");
    run_op(2'b10, 32'h0000_0000, 6'd32, lat(4, 4), 0, 1'b0, "CLZ 00000000");
    run_op(2'b11, 32'h0000_0000, 6'd32, lat(4, 4), 0, 1'b0, "CTZ 00000000");
    run_op(2'b01, 32'hFFFF_FFFF, 6'd0,  lat(4, 1), 0, 1'b0, "ZEROS FFFFFFFF");
    run_op(2'b00, 32'h8000_0000, 6'd1,  lat(4, 1), 0, 1'b0, "ONES 80000000");
    run_op(2'b00, 32'hFFFF_FFFF, 6'd32, lat(4, 4), 5, 1'b0, "ONES FFFFFFFF hold5");
    run_op(2'b01, 32'h0000_0000, 6'd32, lat(4, 4), 0, 1'b0, "ZEROS 00000000 recapture");
    run_op(2'b01, 32'h0000_FFFF, 6'd16, lat(4, 2), 0, 1'b0, "ZEROS 0000FFFF");
    run_op(2'b11, 32'h8000_0000, 6'd31, lat(4, 4), 0, 1'b0, "CTZ 80000000");
    run_op(2'b10, 32'h0000_0001, 6'd31, lat(4, 4), 0, 1'b0, "CLZ 00000001");
    run_op(2'b10, 32'h1234_5678, 6'd3,  lat(4, 1), 0, 1'b1, "CLZ 12345678 drop-early");

    // Abandon an operation with reset two edges after capture.
    start = 1'b1;
    mode  = 2'b00;
    in_v  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midop reset busy", 32'(busy), 32'd0);
    check("midop reset finish", 32'(finish), 32'd0);
    check("midop reset bitcount", 32'(bitcount), 32'd0);
    rst = 1'b1;
    run_op(2'b00, 32'hFF00_FF00, 6'd16, lat(4, 3), 0, 1'b0, "ONES FF00FF00 after reset");

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bitcount_chunked.md
BITCOUNT_CHUNKED -- requirements
Module: bitcount_chunked

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; WIDTH >= 1.
REQ-002 Parameter CHUNK, default 8: bits processed per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise); N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  level request; operation begins when sampled high in IDLE.
REQ-006 mode  input  2  00 ONES, 01 ZEROS, 10 CLZ (leading zeros), 11 CTZ (trailing zeros); sampled with in.
REQ-007 in  input  WIDTH  operand; sampled only on the capture edge.
REQ-008 busy  output  1  high in BUSY.
REQ-009 finish  output  1  high in DONE; bitcount valid.
REQ-010 bitcount  output  COUNT_W = $clog2(WIDTH+1)  result.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-012 IDLE with start=1 at edge t: capture in and mode, clear bitcount and chunk index, go to BUSY.
REQ-013 BUSY: one CHUNK-wide slice processed per edge; ONES/ZEROS/CLZ process MSB-first, CTZ processes LSB-first.
REQ-014 ONES/ZEROS: bitcount += number of ones/zeros in the slice.
REQ-015 CLZ/CTZ: while no one has been found, bitcount += zeros preceding the first one in the slice (in processing order); once a one is found, bitcount SHALL NOT change.
REQ-016 After the Nth slice (edge t+N), go to DONE; finish=1 from that edge.
REQ-017 DONE: stay while start=1; go to IDLE on the first edge with start=0 (finish therefore high for at least one cycle, even if start dropped during BUSY).
REQ-018 Changes to start, in or mode during BUSY/DONE SHALL be ignored; no re-capture until IDLE is revisited.
REQ-019 bitcount SHALL hold its value in IDLE after DONE until the next capture.
REQ-020 Results: all-zero operand gives CLZ=CTZ=WIDTH; all-ones operand gives ONES=WIDTH and ZEROS=0; the accumulator never exceeds WIDTH and never wraps.
REQ-021 CHUNK=WIDTH SHALL be legal: single BUSY cycle, latency 1.

Reset
REQ-022 rst=0 at any edge: state IDLE, busy=0, finish=0, bitcount=0, captured operand cleared; an operation in progress is abandoned.
REQ-023 If start=1 on the first edge with rst=1, capture SHALL occur normally.

Configuration
REQ-024 Macro BITCOUNT_EARLY_EXIT_EN, when defined, makes BUSY go to DONE after the current slice when:
- ONES: the remaining unprocessed bits are all 0;
- ZEROS: the remaining unprocessed bits are all 1;
- CLZ/CTZ: a one has been found.
REQ-025 With BITCOUNT_EARLY_EXIT_EN, results SHALL be identical to the non-early-exit case; only latency (1..N) changes.
REQ-026 Without BITCOUNT_EARLY_EXIT_EN, latency is exactly N cycles for every operand and mode.

Structure
REQ-027 Package bitcount_pkg SHALL hold:
- mode_t enum (ONES, ZEROS, CLZ, CTZ);
- state_t enum (IDLE, BUSY, DONE);
- function count_w(width) returning $clog2(width+1).
REQ-028 Sub-module bitcount_slice (combinational, parameter CHUNK) SHALL return the slice's ones count, leading-zero count, trailing-zero count and any_one; the FSM, shift register and accumulator live in bitcount_chunked.

Verification (WIDTH=32, CHUNK=8)
REQ-029 ONES, in=0xF8524A22 -> bitcount=13; finish rises 4 edges after capture without the macro, with the macro also 4 edges (last slice 0x22 is nonzero).
REQ-030 CLZ, in=0x00000800 -> 20; CTZ, same in -> 11; without the macro finish at edge t+4 in both; with the macro CLZ at t+3 and CTZ at t+2.
REQ-031 in=0x00000000 -> CLZ=32 and CTZ=32 at t+4 with and without the macro; ZEROS, in=0xFFFFFFFF -> 0 (with the macro: finish at t+1).
REQ-032 ONES, in=0x80000000 -> 1; with the macro finish at t+1, without it at t+4.
REQ-033 Reset mid-operation: rst=0 at t+2 -> next cycle busy=0, finish=0, bitcount=0; a subsequent start with ONES, in=0xFF00FF00 -> 16.
REQ-034 Handshake:
- start held high 5 cycles after finish -> finish stays high and bitcount is unchanged;
- start low for 1 cycle, then high -> new capture;
- start dropped at t+1 -> finish high exactly one cycle.
